pingpang_tx: RTL and testbench

- Transmit-side driver for the double-channel ping-pong buffer. It is the producer for that buffer's data_en / data_in_a / data_in_b / switch interface.
- Two independent upstream streams (A and B) arrive on valid/ready handshakes. The block arbitrates between them in bursts and drives switch with a guard interval, so the downstream two-flop switch resync never samples data during a channel change.
- Sits directly upstream of the ping-pong buffer.

---
 rtl/pingpang_tx.sv | 198 +++++++++++++++++++
 tb/tb_pingpang_tx.sv | 458 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pingpang_tx.sv
// -----------------------------------------------------------------------------
// pingpang_tx
//   Transmit-side producer for the double-channel ping-pong buffer. Two
//   upstream valid/ready streams (A and B) are arbitrated in bursts of up to
//   BURST words. Every channel change toggles `switch` and is followed by a
//   GUARD-cycle idle window, so the buffer's two-flop switch resync never
//   samples data while the channel select is moving.
//
// Parameters
//   DW     data width of every data port
//   BURST  max words on one channel before a pending other channel is granted (>=1)
//   GUARD  idle cycles after a switch toggle before data resumes (>=2)
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   a_valid/a_data/a_ready   channel A upstream handshake
//   b_valid/b_data/b_ready   channel B upstream handshake
//   data_en             registered strobe, one per transmitted word
//   data_in_a/data_in_b registered word for the channel it was accepted on
//   switch              registered channel select, 0 = A, 1 = B
//   busy                registered, high whenever the FSM is not idle
//
// Optional build macro PINGPANG_TX_STAT_EN adds statistics outputs:
//   cnt_a, cnt_b (32b) strobes per channel; sw_cnt (16b) switch toggles.
// -----------------------------------------------------------------------------
module pingpang_tx #(
  parameter int DW    = 16,
  parameter int BURST = 4,
  parameter int GUARD = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_valid,
  input  logic [DW-1:0] a_data,
  output logic          a_ready,
  input  logic          b_valid,
  input  logic [DW-1:0] b_data,
  output logic          b_ready,
  output logic          data_en,
  output logic [DW-1:0] data_in_a,
  output logic [DW-1:0] data_in_b,
  output logic          switch,
  output logic          busy
`ifdef PINGPANG_TX_STAT_EN
  ,
  output logic [31:0]   cnt_a,
  output logic [31:0]   cnt_b,
  output logic [15:0]   sw_cnt
`endif
);

  localparam int BCW = $clog2(BURST) + 1;
  localparam int GCW = $clog2(GUARD) + 1;
  localparam logic [BCW-1:0] BURST_LAST = BCW'(BURST - 1);
  localparam logic [GCW-1:0] GUARD_LAST = GCW'(GUARD - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SEND  = 2'd1,
    S_GUARD = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic           switch_q, switch_d;
  logic [BCW-1:0] burst_q, burst_d;
  logic [GCW-1:0] guard_q, guard_d;
  logic           data_en_q;
  logic [DW-1:0]  data_in_a_q, data_in_b_q;
  logic           busy_q;

  logic cur_valid, oth_valid;
  logic accept, toggle;

  // "Current" is whatever channel switch currently selects.
  assign cur_valid = switch_q ? b_valid : a_valid;
  assign oth_valid = switch_q ? a_valid : b_valid;

  // Ready depends only on state and switch, never on valid.
  assign a_ready = (state_q == S_SEND) && !switch_q;
  assign b_ready = (state_q == S_SEND) &&  switch_q;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d  = state_q;
    switch_d = switch_q;
    burst_d  = burst_q;
    guard_d  = guard_q;
    accept   = 1'b0;
    toggle   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (cur_valid) begin
          state_d = S_SEND;
        end else if (oth_valid) begin
          toggle  = 1'b1;
          guard_d = '0;
          state_d = S_GUARD;
        end
      end

      S_SEND: begin
        if (cur_valid) begin
          accept = 1'b1;
          if (burst_q == BURST_LAST) begin
            // Burst complete: hand over only if the other side is waiting,
            // otherwise keep streaming on this channel.
            burst_d = '0;
            if (oth_valid) begin
              toggle  = 1'b1;
              guard_d = '0;
              state_d = S_GUARD;
            end
          end else begin
            burst_d = burst_q + BCW'(1);
          end
        end else if (oth_valid) begin
          toggle  = 1'b1;
          burst_d = '0;
          guard_d = '0;
          state_d = S_GUARD;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_GUARD: begin
        // The toggle is already committed; SEND is entered regardless of
        // whether the new channel is still valid.
        if (guard_q == GUARD_LAST) begin
          guard_d = '0;
          state_d = S_SEND;
        end else begin
          guard_d = guard_q + GCW'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (toggle) switch_d = ~switch_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      switch_q    <= 1'b0;
      burst_q     <= '0;
      guard_q     <= '0;
      data_en_q   <= 1'b0;
      data_in_a_q <= '0;
      data_in_b_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge
      // values, independent of statement order.
      state_q   <= state_d;
      switch_q  <= switch_d;
      burst_q   <= burst_d;
      guard_q   <= guard_d;
      data_en_q <= accept;
      busy_q    <= (state_d != S_IDLE);
      // The word lands on the port of the channel it was accepted from, even
      // when switch flips on this same edge; the other port holds.
      if (accept && !switch_q) data_in_a_q <= a_data;
      if (accept &&  switch_q) data_in_b_q <= b_data;
    end
  end

  assign data_en   = data_en_q;
  assign data_in_a = data_in_a_q;
  assign data_in_b = data_in_b_q;
  assign switch    = switch_q;
  assign busy      = busy_q;

`ifdef PINGPANG_TX_STAT_EN
  logic [31:0] cnt_a_q, cnt_b_q;
  logic [15:0] sw_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_a_q  <= '0;
      cnt_b_q  <= '0;
      sw_cnt_q <= '0;
    end else begin
      if (accept && !switch_q) cnt_a_q  <= cnt_a_q + 32'd1;
      if (accept &&  switch_q) cnt_b_q  <= cnt_b_q + 32'd1;
      if (toggle)              sw_cnt_q <= sw_cnt_q + 16'd1;
    end
  end

  assign cnt_a  = cnt_a_q;
  assign cnt_b  = cnt_b_q;
  assign sw_cnt = sw_cnt_q;
`endif

endmodule

// File: tb/tb_pingpang_tx.sv
// -----------------------------------------------------------------------------
// tb_pingpang_tx
//   Self-checking bench for pingpang_tx. A transaction-level reference model
//   (channel owner, words left in the burst, guard countdown) predicts ready,
//   strobe, data, switch and busy every cycle. Build with
//   PINGPANG_TX_STAT_EN defined to also cover the statistics counters.
// -----------------------------------------------------------------------------
module tb_pingpang_tx;

  localparam int DW    = 16;
  localparam int BURST = 4;
  localparam int GUARD = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_valid, b_valid;
  logic [DW-1:0] a_data, b_data;
  logic          a_ready, b_ready;
  logic          data_en;
  logic [DW-1:0] data_in_a, data_in_b;
  logic          switch;
  logic          busy;
`ifdef PINGPANG_TX_STAT_EN
  logic [31:0]   cnt_a, cnt_b;
  logic [15:0]   sw_cnt;
`endif

  always #5 clk = ~clk;

  pingpang_tx #(.DW(DW), .BURST(BURST), .GUARD(GUARD)) dut (
    .clk       (clk),
    .rst       (rst),
    .a_valid   (a_valid),
    .a_data    (a_data),
    .a_ready   (a_ready),
    .b_valid   (b_valid),
    .b_data    (b_data),
    .b_ready   (b_ready),
    .data_en   (data_en),
    .data_in_a (data_in_a),
    .data_in_b (data_in_b),
    .switch    (switch),
    .busy      (busy)
`ifdef PINGPANG_TX_STAT_EN
    ,
    .cnt_a     (cnt_a),
    .cnt_b     (cnt_b),
    .sw_cnt    (sw_cnt)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: which channel owns the link, whether the link is
  // active, how many guard cycles remain and how many words this burst sent.
  bit            m_ch, m_active;
  int            m_guard_left, m_sent;
  logic          m_en, m_ar, m_br;
  logic [DW-1:0] m_da, m_db;
  bit            m_acc_a, m_acc_b;
  logic [31:0]   m_cnt_a, m_cnt_b;
  logic [15:0]   m_sw;

  logic          obs_ar, obs_br;
  logic [DW-1:0] a_q[$], b_q[$];
  bit            a_en, b_en;

  task automatic model_reset();
    m_ch = 0; m_active = 0; m_guard_left = 0; m_sent = 0;
    m_en = 1'b0; m_da = '0; m_db = '0;
    m_cnt_a = '0; m_cnt_b = '0; m_sw = '0;
  endtask

  task automatic model_step();
    bit cur, oth;
    cur = m_ch ? b_valid : a_valid;
    oth = m_ch ? a_valid : b_valid;
    m_acc_a = 0; m_acc_b = 0; m_en = 1'b0;
    if (m_guard_left > 0) begin
      m_guard_left--;
    end else if (m_active) begin
      if (cur) begin
        m_en = 1'b1;
        if (!m_ch) begin m_da = a_data; m_acc_a = 1; m_cnt_a++; end
        else       begin m_db = b_data; m_acc_b = 1; m_cnt_b++; end
        m_sent++;
        if (m_sent == BURST) begin
          m_sent = 0;
          if (oth) begin m_ch = ~m_ch; m_guard_left = GUARD; m_sw++; end
        end
      end else if (oth) begin
        m_ch = ~m_ch; m_sent = 0; m_guard_left = GUARD; m_sw++;
      end else begin
        m_active = 0;
      end
    end else begin
      if (cur) m_active = 1;
      else if (oth) begin m_ch = ~m_ch; m_guard_left = GUARD; m_active = 1; m_sw++; end
    end
  endtask

  function automatic logic [2*DW+4:0] exp_vec();
    return {m_ar, m_br, m_en, m_ch, (m_active || m_guard_left > 0), m_da, m_db};
  endfunction

  function automatic logic [2*DW+4:0] obs_vec();
    return {obs_ar, obs_br, data_en, switch, busy, data_in_a, data_in_b};
  endfunction

  // One clock: drive sources, sample ready before the edge, advance the
  // model, then return 1 time unit after the edge with outputs settled.
  task automatic tick();
    a_valid = a_en && (a_q.size() != 0);
    a_data  = (a_q.size() != 0) ? a_q[0] : '0;
    b_valid = b_en && (b_q.size() != 0);
    b_data  = (b_q.size() != 0) ? b_q[0] : '0;
    #1;
    obs_ar = a_ready;
    obs_br = b_ready;
    m_ar = m_active && (m_guard_left == 0) && !m_ch;
    m_br = m_active && (m_guard_left == 0) &&  m_ch;
    model_step();
    if (m_acc_a) void'(a_q.pop_front());
    if (m_acc_b) void'(b_q.pop_front());
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    #2 rst = 1'b1;
    model_reset();
    @(posedge clk);
    #3 rst = 1'b0;
  endtask

  task automatic test_reset();
    a_en = 0; b_en = 0; a_valid = 0; b_valid = 0; a_data = '0; b_data = '0;
    rst = 1'b1;
    model_reset();
    #2;
    n_checks++;
    if ({data_en, switch, busy, data_in_a, data_in_b} !== '0) begin
      n_fail++; $display("FAIL reset_outputs got %h required 0", {data_en, switch, busy, data_in_a, data_in_b});
    end
    n_checks++;
    if ({a_ready, b_ready} !== 2'b00) begin
      n_fail++; $display("FAIL reset_ready got %b required 00", {a_ready, b_ready});
    end
    @(posedge clk);
    #3 rst = 1'b0;
    tick();
    n_checks++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL reset_idle got %h required %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_a_only();
    logic [DW-1:0] exp_w [3];
    logic [DW-1:0] got[$];
    int first_acc, first_en, last_en;
    exp_w = '{16'h0011, 16'h0012, 16'h0013};
    first_acc = -1; first_en = -1; last_en = -1;
    pulse_reset();
    a_q = '{16'h0011, 16'h0012, 16'h0013}; b_q.delete();
    a_en = 1; b_en = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (first_acc < 0 && a_valid && obs_ar) first_acc = k;
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL a_only_cycle%0d got %h required %h", k, obs_vec(), exp_vec());
      end
      n_checks++;
      if (obs_br !== 1'b0 || switch !== 1'b0) begin
        n_fail++; $display("FAIL a_only_b_side cycle%0d b_ready=%b switch=%b required 0 0", k, obs_br, switch);
      end
      if (data_en === 1'b1) begin
        if (first_en < 0) first_en = k;
        last_en = k;
        got.push_back(data_in_a);
      end
    end
    n_checks++;
    if (first_acc < 0 || first_en !== first_acc) begin
      n_fail++; $display("FAIL a_only_latency first strobe %0d required %0d", first_en, first_acc);
    end
    n_checks++;
    if (got.size() != 3 || last_en - first_en != 2) begin
      n_fail++; $display("FAIL a_only_strobes count %0d span %0d required 3 2", got.size(), last_en - first_en);
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (got[i] !== exp_w[i]) begin
          n_fail++; $display("FAIL a_only_word%0d got %h required %h", i, got[i], exp_w[i]);
        end
      end
    end
  endtask

  // Runs straight after test_a_only: idle with switch=0 and data_in_a=0013.
  task automatic test_b_from_idle();
    int sw_tick, en_tick;
    sw_tick = -1; en_tick = -1;
    a_en = 0; a_q.delete();
    b_q = '{16'hBEEF}; b_en = 1;
    for (int k = 0; k < 8; k++) begin
      tick();
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL b_idle_cycle%0d got %h required %h", k, obs_vec(), exp_vec());
      end
      if (sw_tick < 0 && switch === 1'b1) sw_tick = k;
      if (en_tick < 0 && data_en === 1'b1) begin
        en_tick = k;
        n_checks++;
        if (data_in_b !== 16'hBEEF || data_in_a !== 16'h0013) begin
          n_fail++; $display("FAIL b_idle_data a=%h b=%h required 0013 BEEF", data_in_a, data_in_b);
        end
      end
    end
    n_checks++;
    if (sw_tick != 0 || en_tick - sw_tick != GUARD + 1) begin
      n_fail++; $display("FAIL b_idle_timing switch@%0d strobe@%0d required 0 %0d", sw_tick, en_tick, GUARD + 1);
    end
  endtask

  task automatic test_fairness();
    int gap, run, n_edges, n_strobes;
    bit expect_first, done;
    logic prev_sw;
    gap = 0; run = 0; n_edges = 0; n_strobes = 0; expect_first = 0; done = 0;
    prev_sw = 1'b0;
    pulse_reset();
    a_q.delete(); b_q.delete();
    for (int i = 0; i < 20; i++) begin
      a_q.push_back(DW'(16'hA000 + i));
      b_q.push_back(DW'(16'hB000 + i));
    end
    a_en = 1; b_en = 1;
    for (int k = 0; k < 80 && !done; k++) begin
      tick();
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL fair_cycle%0d got %h required %h", k, obs_vec(), exp_vec());
      end
      if (switch !== prev_sw) begin
        n_edges++; gap = GUARD; expect_first = 0;
      end else if (gap > 0) begin
        n_checks++;
        if (data_en !== 1'b0) begin
          n_fail++; $display("FAIL fair_guard_gap cycle%0d data_en=%b required 0", k, data_en);
        end
        gap--;
        if (gap == 0) expect_first = 1;
      end else if (expect_first) begin
        expect_first = 0;
        n_checks++;
        if (data_en !== 1'b1) begin
          n_fail++; $display("FAIL fair_resume cycle%0d data_en=%b required 1", k, data_en);
        end
      end
      prev_sw = switch;
      if (data_en === 1'b1) begin
        run++; n_strobes++;
      end else if (run > 0) begin
        n_checks++;
        if (run != BURST) begin
          n_fail++; $display("FAIL fair_burst_len got %0d required %0d", run, BURST);
        end
        run = 0;
      end
      if (m_cnt_b == 32'd12) done = 1;
    end
    n_checks++;
    if (!done || n_edges != 6 || n_strobes != 24) begin
      n_fail++; $display("FAIL fair_totals edges %0d strobes %0d required 6 24", n_edges, n_strobes);
    end
`ifdef PINGPANG_TX_STAT_EN
    n_checks++;
    if (cnt_a !== 32'd12 || cnt_b !== 32'd12 || sw_cnt !== 16'd6) begin
      n_fail++; $display("FAIL fair_stats a=%0d b=%0d sw=%0d required 12 12 6", cnt_a, cnt_b, sw_cnt);
    end
`endif
    a_en = 0; b_en = 0; a_q.delete(); b_q.delete();
    for (int k = 0; k < 5; k++) begin
      tick();
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL fair_drain%0d got %h required %h", k, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_a_long();
    int first_en, last_en, n_strobes;
    first_en = -1; last_en = -1; n_strobes = 0;
    pulse_reset();
    a_q.delete(); b_q.delete();
    for (int i = 0; i < 10; i++) a_q.push_back(DW'($urandom));
    a_en = 1; b_en = 0;
    for (int k = 0; k < 14; k++) begin
      tick();
      n_checks++;
      if (obs_vec() !== exp_vec() || switch !== 1'b0) begin
        n_fail++; $display("FAIL a_long_cycle%0d got %h required %h", k, obs_vec(), exp_vec());
      end
      if (data_en === 1'b1) begin
        if (first_en < 0) first_en = k;
        last_en = k; n_strobes++;
      end
    end
    n_checks++;
    if (n_strobes != 10 || last_en - first_en != 9) begin
      n_fail++; $display("FAIL a_long_strobes count %0d span %0d required 10 9", n_strobes, last_en - first_en);
    end
  endtask

  task automatic test_reset_mid();
    int remaining, n_strobes;
    bit hit;
    // Reset while guarding.
    pulse_reset();
    a_q.delete(); b_q.delete();
    for (int i = 0; i < 6; i++) begin
      a_q.push_back(DW'(16'h1100 + i));
      b_q.push_back(DW'(16'h2200 + i));
    end
    a_en = 1; b_en = 1; hit = 0;
    for (int k = 0; k < 20 && !hit; k++) begin
      tick();
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL rmid_pre_cycle%0d got %h required %h", k, obs_vec(), exp_vec());
      end
      if (m_guard_left > 0) hit = 1;
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (!hit || {data_en, switch, busy, data_in_a, data_in_b} !== '0) begin
      n_fail++; $display("FAIL rmid_guard_async got %h required 0 (guard reached %0d)", {data_en, switch, busy, data_in_a, data_in_b}, hit);
    end
    model_reset();
    @(posedge clk);
    #1;
    n_checks++;
    if ({a_ready, b_ready, data_en} !== 3'b000) begin
      n_fail++; $display("FAIL rmid_guard_hold got %b required 000", {a_ready, b_ready, data_en});
    end
    #2 rst = 1'b0;
    remaining = a_q.size() + b_q.size();
    n_strobes = 0;
    for (int k = 0; k < 60; k++) begin
      tick();
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL rmid_post_cycle%0d got %h required %h", k, obs_vec(), exp_vec());
      end
      if (data_en === 1'b1) n_strobes++;
    end
    n_checks++;
    if (n_strobes != remaining) begin
      n_fail++; $display("FAIL rmid_guard_words got %0d required %0d", n_strobes, remaining);
    end

    // Reset while sending with a word in the output register.
    a_q.delete(); b_q.delete();
    for (int i = 0; i < 4; i++) a_q.push_back(DW'(16'h3300 + i));
    a_en = 1; b_en = 0; hit = 0;
    for (int k = 0; k < 10 && !hit; k++) begin
      tick();
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL rmid_send_cycle%0d got %h required %h", k, obs_vec(), exp_vec());
      end
      if (m_en) hit = 1;
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (!hit || {data_en, busy, data_in_a} !== '0) begin
      n_fail++; $display("FAIL rmid_send_async got %h required 0 (word registered %0d)", {data_en, busy, data_in_a}, hit);
    end
    model_reset();
    remaining = a_q.size();
    @(posedge clk);
    #1;
    n_checks++;
    if ({a_ready, data_en} !== 2'b00) begin
      n_fail++; $display("FAIL rmid_send_hold got %b required 00", {a_ready, data_en});
    end
    #2 rst = 1'b0;
    a_en = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (data_en !== 1'b0 || obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL rmid_quiet%0d got %h required %h", k, obs_vec(), exp_vec());
      end
    end
    a_en = 1; n_strobes = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL rmid_resend_cycle%0d got %h required %h", k, obs_vec(), exp_vec());
      end
      if (data_en === 1'b1) n_strobes++;
    end
    n_checks++;
    if (n_strobes != remaining) begin
      n_fail++; $display("FAIL rmid_send_words got %0d required %0d", n_strobes, remaining);
    end
  endtask

  task automatic test_random();
    pulse_reset();
    a_q.delete(); b_q.delete();
    for (int k = 0; k < 600; k++) begin
      a_en = ($urandom_range(0, 3) != 0);
      b_en = ($urandom_range(0, 4) > 1);
      if (a_q.size() < 3) a_q.push_back(DW'($urandom));
      if (b_q.size() < 3) b_q.push_back(DW'($urandom));
      tick();
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL random_cycle%0d got %h required %h", k, obs_vec(), exp_vec());
      end
    end
`ifdef PINGPANG_TX_STAT_EN
    n_checks++;
    if (cnt_a !== m_cnt_a || cnt_b !== m_cnt_b || sw_cnt !== m_sw) begin
      n_fail++; $display("FAIL random_stats got %0d %0d %0d required %0d %0d %0d", cnt_a, cnt_b, sw_cnt, m_cnt_a, m_cnt_b, m_sw);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_a_only();
    test_b_from_idle();
    test_fairness();
    test_a_long();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
